// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer, empty flag, write-pointer
// synchroniser and a registered show-ahead output stage with a valid/ready handshake.
module fifo_rd_ctrl #(
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned ADDRSIZE = 8
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic [ADDRSIZE:0]   rwptr_gray,
   input  logic [DATASIZE-1:0] rmem_data,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic [ADDRSIZE:0]   rlevel,
   output logic [DATASIZE-1:0] rdata,
   output logic                rvalid,
   input  logic                rready
);

   localparam int unsigned PW = ADDRSIZE + 1;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Binary value is the XOR of every right shift of the Gray code.
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = g;
      for (int i = 1; i < int'(PW); i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   logic [PW-1:0]       rq1, rq2;
   logic [PW-1:0]       rbin;

   logic                fetch_c;
   logic [PW-1:0]       rbin_nxt;
   logic [PW-1:0]       rgraynext;
   logic                rempty_nxt;
   logic [DATASIZE-1:0] rdata_nxt;
   logic                rvalid_nxt;

   // A new word is taken whenever memory has one and the output stage is free or being drained.
   always_comb begin
      fetch_c    = 1'b0;
      rbin_nxt   = rbin;
      rgraynext  = rptr;
      rempty_nxt = rempty;
      rdata_nxt  = rdata;
      rvalid_nxt = rvalid;

      fetch_c    = !rempty && (!rvalid || rready);
      rbin_nxt   = rbin + PW'(fetch_c);
      rgraynext  = bin2gray(rbin_nxt);
      rempty_nxt = (rgraynext == rq2);

      if (fetch_c) begin
         rdata_nxt  = rmem_data;
         rvalid_nxt = 1'b1;
      end else if (rvalid && rready) begin
         rvalid_nxt = 1'b0;
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         rq1    <= '0;
         rq2    <= '0;
         rbin   <= '0;
         rptr   <= '0;
         rempty <= 1'b1;
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rq1    <= rwptr_gray;
         rq2    <= rq1;
         rbin   <= rbin_nxt;
         rptr   <= rgraynext;
         rempty <= rempty_nxt;
         rdata  <= rdata_nxt;
         rvalid <= rvalid_nxt;
      end
   end

   assign raddr  = rbin[ADDRSIZE-1:0];
   // Output-stage word is already consumed from memory, so it is not part of the level.
   assign rlevel = gray2bin(rq2) - rbin;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with ADDRSIZE=4, DATASIZE=8; memory is modelled here.
module tb_fifo_rd_ctrl;

   logic       rclk;
   logic       rrst;
   logic [4:0] rwptr_gray;
   logic [7:0] rmem_data;
   logic [3:0] raddr;
   logic [4:0] rptr;
   logic       rempty;
   logic [4:0] rlevel;
   logic [7:0] rdata;
   logic       rvalid;
   logic       rready;

   logic [7:0] mem [16];
   int         n_cmp;
   int         n_bad;

   fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rwptr_gray(rwptr_gray),
      .rmem_data (rmem_data),
      .raddr     (raddr),
      .rptr      (rptr),
      .rempty    (rempty),
      .rlevel    (rlevel),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .rready    (rready)
   );

   assign rmem_data = mem[raddr];

   always #5 rclk = ~rclk;

   function automatic logic [4:0] gray5(input logic [4:0] x);
      return x ^ (x >> 1);
   endfunction

   // Advance to just after the next rising edge; all driving and sampling happen here.
   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic do_reset();
      rrst       = 1'b1;
      rwptr_gray = '0;
      rready     = 1'b0;
      tick();
      tick();
      rrst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp += 6;
      if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
      if (rempty !== 1'b1) begin n_bad++; $display("FAIL reset_rempty: got %b want 1", rempty); end
      if (rptr !== 5'h00) begin n_bad++; $display("FAIL reset_rptr: got %h want 00", rptr); end
      if (raddr !== 4'h0) begin n_bad++; $display("FAIL reset_raddr: got %h want 0", raddr); end
      if (rlevel !== 5'd0) begin n_bad++; $display("FAIL reset_rlevel: got %0d want 0", rlevel); end
      if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
   endtask

   // One word at address 0 with the consumer stalled; checks every stage of the latency.
   task automatic run_single_word();
      mem[0]     = 8'hA5;
      rready     = 1'b0;
      rwptr_gray = 5'h01;
      tick();
      tick();
      n_cmp += 2;
      if (rlevel !== 5'd1) begin n_bad++; $display("FAIL single_e2_rlevel: got %0d want 1", rlevel); end
      if (rempty !== 1'b1) begin n_bad++; $display("FAIL single_e2_rempty: got %b want 1", rempty); end
      tick();
      n_cmp += 2;
      if (rempty !== 1'b0) begin n_bad++; $display("FAIL single_e3_rempty: got %b want 0", rempty); end
      if (rvalid !== 1'b0) begin n_bad++; $display("FAIL single_e3_rvalid: got %b want 0", rvalid); end
      tick();
      n_cmp += 6;
      if (rvalid !== 1'b1) begin n_bad++; $display("FAIL single_e4_rvalid: got %b want 1", rvalid); end
      if (rdata !== 8'hA5) begin n_bad++; $display("FAIL single_e4_rdata: got %h want a5", rdata); end
      if (rptr !== 5'h01) begin n_bad++; $display("FAIL single_e4_rptr: got %h want 01", rptr); end
      if (raddr !== 4'h1) begin n_bad++; $display("FAIL single_e4_raddr: got %h want 1", raddr); end
      if (rempty !== 1'b1) begin n_bad++; $display("FAIL single_e4_rempty: got %b want 1", rempty); end
      if (rlevel !== 5'd0) begin n_bad++; $display("FAIL single_e4_rlevel: got %0d want 0", rlevel); end
   endtask

   task automatic test_single_word();
      do_reset();
      run_single_word();
   endtask

   task automatic test_backpressure();
      do_reset();
      mem[0]     = 8'h11;
      mem[1]     = 8'h22;
      mem[2]     = 8'h33;
      rwptr_gray = 5'h02;
      for (int i = 0; i < 7; i++) tick();
      n_cmp += 4;
      if (rvalid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_rvalid: got %b want 1", rvalid); end
      if (rdata !== 8'h11) begin n_bad++; $display("FAIL bp_hold_rdata: got %h want 11", rdata); end
      if (rlevel !== 5'd2) begin n_bad++; $display("FAIL bp_hold_rlevel: got %0d want 2", rlevel); end
      if (rptr !== 5'h01) begin n_bad++; $display("FAIL bp_hold_rptr: got %h want 01", rptr); end
      rready = 1'b1;
      tick();
      n_cmp += 2;
      if (rvalid !== 1'b1) begin n_bad++; $display("FAIL bp_d1_rvalid: got %b want 1", rvalid); end
      if (rdata !== 8'h22) begin n_bad++; $display("FAIL bp_d1_rdata: got %h want 22", rdata); end
      tick();
      n_cmp += 3;
      if (rvalid !== 1'b1) begin n_bad++; $display("FAIL bp_d2_rvalid: got %b want 1", rvalid); end
      if (rdata !== 8'h33) begin n_bad++; $display("FAIL bp_d2_rdata: got %h want 33", rdata); end
      if (rempty !== 1'b1) begin n_bad++; $display("FAIL bp_d2_rempty: got %b want 1", rempty); end
      tick();
      n_cmp += 3;
      if (rvalid !== 1'b0) begin n_bad++; $display("FAIL bp_d3_rvalid: got %b want 0", rvalid); end
      if (rdata !== 8'h33) begin n_bad++; $display("FAIL bp_d3_rdata: got %h want 33", rdata); end
      if (rlevel !== 5'd0) begin n_bad++; $display("FAIL bp_d3_rlevel: got %0d want 0", rlevel); end
      rready = 1'b0;
   endtask

   task automatic test_wrap();
      int got;
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
      rready     = 1'b1;
      rwptr_gray = 5'h18;
      tick();
      tick();
      n_cmp++;
      if (rlevel !== 5'd16) begin n_bad++; $display("FAIL wrap_full_rlevel: got %0d want 16", rlevel); end
      tick();
      for (int k = 0; k < 16; k++) begin
         tick();
         n_cmp++;
         if (rvalid !== 1'b1 || rdata !== 8'h40 + 8'(k)) begin
            n_bad++;
            $display("FAIL wrap_word%0d: got v=%b d=%h want v=1 d=%h", k, rvalid, rdata, 8'h40 + 8'(k));
         end
      end
      n_cmp += 3;
      if (raddr !== 4'h0) begin n_bad++; $display("FAIL wrap_raddr: got %h want 0", raddr); end
      if (rptr !== 5'h18) begin n_bad++; $display("FAIL wrap_rptr: got %h want 18", rptr); end
      if (rempty !== 1'b1) begin n_bad++; $display("FAIL wrap_rempty: got %b want 1", rempty); end
      mem[0]     = 8'hC0;
      mem[1]     = 8'hC1;
      mem[2]     = 8'hC2;
      rwptr_gray = gray5(5'd19);
      got        = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (rvalid === 1'b1) begin
            n_cmp++;
            if (got >= 3 || rdata !== 8'hC0 + 8'(got)) begin
               n_bad++;
               $display("FAIL wrap_extra%0d: got %h want %h", got, rdata, 8'hC0 + 8'(got));
            end
            got++;
         end
      end
      n_cmp++;
      if (got != 3) begin n_bad++; $display("FAIL wrap_extra_count: got %0d want 3", got); end
   endtask

   task automatic test_streaming();
      int         got;
      bit         started;
      logic [4:0] wbin;
      do_reset();
      rready  = 1'b1;
      wbin    = '0;
      got     = 0;
      started = 0;
      for (int c = 0; c < 60; c++) begin
         if (wbin < 5'd20) begin
            mem[wbin[3:0]] = 8'h80 + 8'(wbin);
            wbin           = wbin + 5'd1;
            rwptr_gray     = gray5(wbin);
         end
         tick();
         if (rvalid === 1'b1) begin
            started = 1;
            n_cmp++;
            if (rdata !== 8'h80 + 8'(got)) begin
               n_bad++;
               $display("FAIL stream_word%0d: got %h want %h", got, rdata, 8'h80 + 8'(got));
            end
            got++;
         end else if (started && got < 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_bubble: got rvalid=0 after %0d words want 1", got);
         end
      end
      n_cmp++;
      if (got != 20) begin n_bad++; $display("FAIL stream_count: got %0d want 20", got); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 8; i++) mem[i] = 8'h60 + 8'(i);
      rwptr_gray = gray5(5'd6);
      for (int i = 0; i < 6; i++) tick();
      n_cmp += 2;
      if (rvalid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_rvalid: got %b want 1", rvalid); end
      if (rlevel !== 5'd5) begin n_bad++; $display("FAIL mid_pre_rlevel: got %0d want 5", rlevel); end
      rrst       = 1'b1;
      rwptr_gray = '0;
      tick();
      rrst = 1'b0;
      n_cmp += 4;
      if (rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid: got %b want 0", rvalid); end
      if (rempty !== 1'b1) begin n_bad++; $display("FAIL mid_rempty: got %b want 1", rempty); end
      if (rptr !== 5'h00) begin n_bad++; $display("FAIL mid_rptr: got %h want 00", rptr); end
      if (rlevel !== 5'd0) begin n_bad++; $display("FAIL mid_rlevel: got %0d want 0", rlevel); end
      run_single_word();
   endtask

   initial begin
      rclk       = 1'b0;
      rrst       = 1'b1;
      rwptr_gray = '0;
      rready     = 1'b0;
      n_cmp      = 0;
      n_bad      = 0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      test_reset();
      test_single_word();
      test_backpressure();
      test_wrap();
      test_streaming();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
